// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the KEY input conditioner.
// Defaults assume the 50 MHz board clock.
package key_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  localparam int MAIN_FREQ             = 50000000;
  localparam int DEF_DEBOUNCE_CYCLES   = MAIN_FREQ / 100;  // 10 ms
  localparam int DEF_REPEAT_DELAY      = MAIN_FREQ / 2;    // 500 ms
  localparam int DEF_REPEAT_PERIOD     = MAIN_FREQ / 10;   // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter width covers debounce and repeat timing so terminal counts fit.
  function automatic int cnt_width(input int db, input int rd, input int rp);
    return $clog2(max3(db, rd, rp) + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, debounce counter and auto-repeat FSM.
// Exposes next-cycle level/rise/step so the top can register masked pulses.
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic srst,
  input  logic key_n,
  input  logic hold,
  output logic level,
  output logic level_next,
  output logic rise_next,
  output logic step_next
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             sync;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  rep_state_t       state_q, state_d;
  logic             step_d;
  logic             rise, fall;

  assign sync1_d = key_n;
  assign sync2_d = sync1_q;
  assign sync    = ~sync2_q;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync != level_q) begin
      if (db_cnt_q == DB_TERM) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Kept in its own block: hold depends on level_next of every key.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    step_d    = 1'b0;
    if (hold || fall) begin
      state_d   = ST_IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            step_d    = 1'b1;
            rep_cnt_d = '0;
            if (REPEAT_DELAY != 0) state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (rep_cnt_q == RD_TERM) begin
            step_d    = 1'b1;
            rep_cnt_d = '0;
            state_d   = ST_REPEAT;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rep_cnt_q == RP_TERM) begin
            step_d    = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      state_q   <= state_d;
    end
  end

  assign level      = level_q;
  assign level_next = level_d;
  assign rise_next  = rise;
  assign step_next  = step_d;

endmodule

// File: rtl/key_conditioner.sv
// KEY conditioner top: per-key debounce/repeat plus the all-keys chord lock
// that silences press/step pulses until every key is released.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int KEY_CNT         = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [KEY_CNT-1:0] KEY,
  output logic [KEY_CNT-1:0] key_level,
  output logic [KEY_CNT-1:0] key_press,
  output logic [KEY_CNT-1:0] key_step,
  output logic               chord,
  output logic               chord_active
);

  logic [KEY_CNT-1:0] level_next, rise_next, step_next;
  logic [KEY_CNT-1:0] press_q, press_d, step_q, step_d;
  logic               chord_q, chord_d;
  logic               lock_q, lock_d;

  generate
    for (genvar gi = 0; gi < KEY_CNT; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_key (
        .clk       (CLOCK_50),
        .srst      (reset),
        .key_n     (KEY[gi]),
        .hold      (lock_d),
        .level     (key_level[gi]),
        .level_next(level_next[gi]),
        .rise_next (rise_next[gi]),
        .step_next (step_next[gi])
      );
    end
  endgenerate

  // Lock uses next-cycle levels so a chord suppresses the completing key's pulses.
  always_comb begin
    chord_d = (&level_next) & ~lock_q;
    lock_d  = lock_q ? (|level_next) : (&level_next);
  end

  always_comb begin
    press_d = lock_d ? '0 : rise_next;
    step_d  = lock_d ? '0 : step_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      press_q <= '0;
      step_q  <= '0;
      chord_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      press_q <= press_d;
      step_q  <= step_d;
      chord_q <= chord_d;
      lock_q  <= lock_d;
    end
  end

  assign key_press    = press_q;
  assign key_step     = step_q;
  assign chord        = chord_q;
  assign chord_active = lock_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Table-driven bench for key_conditioner with small debounce/repeat timings.
// Each scenario lists KEY/reset stimulus and expected outputs per cycle.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'hF;
  logic [3:0] key_nr = 4'hF;

  logic [3:0] key_level, key_press, key_step;
  logic       chord, chord_active;
  logic [3:0] key_level_nr, key_press_nr, key_step_nr;
  logic       chord_nr, chord_active_nr;

  always #5 clk = ~clk;

  key_conditioner #(
    .KEY_CNT(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(key),
    .key_level(key_level), .key_press(key_press), .key_step(key_step),
    .chord(chord), .chord_active(chord_active)
  );

  key_conditioner #(
    .KEY_CNT(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)
  ) dut_nr (
    .CLOCK_50(clk), .reset(reset), .KEY(key_nr),
    .key_level(key_level_nr), .key_press(key_press_nr), .key_step(key_step_nr),
    .chord(chord_nr), .chord_active(chord_active_nr)
  );

  typedef struct {
    bit         is_stim;
    int         cyc;
    logic       rst;
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] stp;
    logic       chd;
    logic       act;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [13:0] outs;  // {lvl, prs, stp, chd, act}
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add_s(input int c, input logic [3:0] k, input logic r);
    vec_t v;
    v = '{default: 0};
    v.is_stim = 1'b1;
    v.cyc = c;
    v.key = k;
    v.rst = r;
    tbl.push_back(v);
  endtask

  task automatic add_e(input int c, input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] s, input logic ch, input logic a);
    vec_t v;
    v = '{default: 0};
    v.cyc = c;
    v.lvl = l;
    v.prs = p;
    v.stp = s;
    v.chd = ch;
    v.act = a;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    key    = 4'hF;
    key_nr = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({key_level, key_press, key_step, chord, chord_active} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_state got %b want all zero",
               {key_level, key_press, key_step, chord, chord_active});
    end
    n_vec++;
    if ({key_level_nr, key_press_nr, key_step_nr, chord_nr, chord_active_nr} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_state_nr got %b want all zero",
               {key_level_nr, key_press_nr, key_step_nr, chord_nr, chord_active_nr});
    end
  endtask

  // Cycle n: stimulus driven just after edge n, outputs sampled on the following negedge.
  task automatic run(input string name, input int ncyc);
    logic [3:0]  lvl_e, prs_e, stp_e;
    logic        chd_e, act_e;
    logic [13:0] got;
    sb_t         e;
    int          start_bad;
    lvl_e = 4'd0;
    act_e = 1'b0;
    start_bad = n_bad;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      prs_e = 4'd0;
      stp_e = 4'd0;
      chd_e = 1'b0;
      foreach (tbl[i]) begin
        if (tbl[i].cyc == n) begin
          if (tbl[i].is_stim) begin
            key   = tbl[i].key;
            reset = tbl[i].rst;
          end else begin
            lvl_e = tbl[i].lvl;
            prs_e = tbl[i].prs;
            stp_e = tbl[i].stp;
            chd_e = tbl[i].chd;
            act_e = tbl[i].act;
          end
        end
      end
      e.cyc  = n;
      e.outs = {lvl_e, prs_e, stp_e, chd_e, act_e};
      sb_q.push_back(e);
      @(negedge clk);
      got = {key_level, key_press, key_step, chord, chord_active};
      e = sb_q.pop_front();
      n_vec++;
      if (got !== e.outs) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got lvl=%b prs=%b stp=%b chd=%b act=%b want lvl=%b prs=%b stp=%b chd=%b act=%b",
                 name, e.cyc, got[13:10], got[9:6], got[5:2], got[1], got[0],
                 e.outs[13:10], e.outs[9:6], e.outs[5:2], e.outs[1], e.outs[0]);
      end
    end
    tbl.delete();
    $display("scenario %s: %0d cycles, %0d miscompares", name, ncyc, n_bad - start_bad);
  endtask

  task automatic run_no_repeat();
    int steps;
    int presses;
    steps = 0;
    presses = 0;
    for (int n = 0; n < 115; n++) begin
      @(posedge clk);
      #1;
      if (n == 0)   key_nr = 4'b1110;
      if (n == 100) key_nr = 4'b1111;
      @(negedge clk);
      if (n == 6) begin
        n_vec++;
        if ({key_level_nr, key_press_nr, key_step_nr} !== 12'b0001_0001_0001) begin
          n_bad++;
          $display("FAIL no_repeat_accept cyc=6 got %b want %b",
                   {key_level_nr, key_press_nr, key_step_nr}, 12'b0001_0001_0001);
        end
      end
      steps   += int'(key_step_nr[0]);
      presses += int'(key_press_nr[0]);
    end
    n_vec++;
    if (steps != 1) begin
      n_bad++;
      $display("FAIL no_repeat_steps got %0d want 1", steps);
    end
    n_vec++;
    if (presses != 1) begin
      n_bad++;
      $display("FAIL no_repeat_presses got %0d want 1", presses);
    end
    n_vec++;
    if ({key_level_nr, chord_nr, chord_active_nr} !== 6'd0) begin
      n_bad++;
      $display("FAIL no_repeat_release got %b want 000000",
               {key_level_nr, chord_nr, chord_active_nr});
    end
    $display("scenario no_repeat: %0d steps, %0d presses", steps, presses);
  endtask

  initial begin
    do_reset();

    // Clean press of KEY[0]; release six cycles after KEY rises.
    add_s(0, 4'b1110, 1'b0);
    add_s(12, 4'b1111, 1'b0);
    add_e(6, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    add_e(18, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("clean_press", 30);
    do_reset();

    // Bounce on KEY[1], a 3-cycle glitch (rejected) and an exact 4-cycle pulse (accepted).
    for (int i = 0; i < 10; i++) add_s(2 * i, (i % 2 == 0) ? 4'b1101 : 4'b1111, 1'b0);
    add_s(24, 4'b1101, 1'b0);
    add_s(27, 4'b1111, 1'b0);
    add_s(34, 4'b1101, 1'b0);
    add_s(38, 4'b1111, 1'b0);
    add_e(40, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
    add_e(44, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("bounce", 55);
    do_reset();

    // Auto-repeat on KEY[2]; the repeat due at cycle 56 coincides with release.
    add_s(0, 4'b1011, 1'b0);
    add_s(50, 4'b1111, 1'b0);
    add_e(6, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0);
    for (int t = 26; t <= 51; t += 5) add_e(t, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
    add_e(56, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("auto_repeat", 70);
    do_reset();

    // Chord: staggered presses, partial release/re-press under lock, then fresh press.
    add_s(0, 4'b1110, 1'b0);
    add_s(1, 4'b1100, 1'b0);
    add_s(2, 4'b1000, 1'b0);
    add_s(3, 4'b0000, 1'b0);
    add_s(20, 4'b0010, 1'b0);
    add_s(30, 4'b0000, 1'b0);
    add_s(40, 4'b1111, 1'b0);
    add_s(50, 4'b1110, 1'b0);
    add_s(60, 4'b1111, 1'b0);
    add_e(6, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    add_e(7, 4'b0011, 4'b0010, 4'b0010, 1'b0, 1'b0);
    add_e(8, 4'b0111, 4'b0100, 4'b0100, 1'b0, 1'b0);
    add_e(9, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1);
    add_e(26, 4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add_e(36, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add_e(46, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_e(56, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    add_e(66, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("chord", 75);
    do_reset();

    // Reset pulse while KEY[3] is held: re-accepted with a fresh press and repeat timing.
    add_s(0, 4'b0111, 1'b0);
    add_s(10, 4'b0111, 1'b1);
    add_s(11, 4'b0111, 1'b0);
    add_s(35, 4'b1111, 1'b0);
    add_e(6, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
    add_e(11, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    add_e(17, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0);
    add_e(37, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
    add_e(41, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("reset_mid_hold", 50);
    do_reset();

    // Two independent keys pressed together pulse in the same cycles.
    add_s(0, 4'b1100, 1'b0);
    add_s(28, 4'b1111, 1'b0);
    add_e(6, 4'b0011, 4'b0011, 4'b0011, 1'b0, 1'b0);
    add_e(26, 4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b0);
    add_e(31, 4'b0011, 4'b0000, 4'b0011, 1'b0, 1'b0);
    add_e(34, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    run("simultaneous", 45);
    do_reset();

    run_no_repeat();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
